// File: rtl/button_debouncer_pkg.sv
// Shared types and sizing helpers for the button debouncer.
// The optional edge-pulse feature is controlled by BUTTON_DEBOUNCER_EDGE_EN.
package button_debouncer_pkg;

    typedef enum logic {
        STABLE   = 1'b0,
        COUNTING = 1'b1
    } deb_state_t;

    // Number of cycles the synchronized input must disagree before it is accepted.
    function automatic int calc_n(input int clock_frequency, input int debounce_ms);
        return (clock_frequency / 1000) * debounce_ms;
    endfunction

    function automatic int calc_cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/debounce_cell.sv
// Single-channel debouncer: 2-flop synchronizer, stability counter FSM, optional edge pulses.
// Edge pulses exist only when BUTTON_DEBOUNCER_EDGE_EN is defined; otherwise they are tied low.
module debounce_cell
    import button_debouncer_pkg::*;
#(
    parameter int N     = 1000,
    parameter int CNT_W = 10
) (
    input  logic clock,
    input  logic reset_n,
    input  logic button_in,
    output logic button_out,
    output logic rise_pulse,
    output logic fall_pulse
);

    localparam logic [CNT_W-1:0] N_CNT = CNT_W'(N);

    logic             sync1_reg;
    logic             sync2_reg;
    deb_state_t       state_reg;
    logic [CNT_W-1:0] count_reg;
    logic             out_reg;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
        end else begin
            sync1_reg <= button_in;
            sync2_reg <= sync1_reg;
        end
    end

    // The output only moves once the synced level has disagreed for N+1 consecutive samples.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= STABLE;
            count_reg <= '0;
            out_reg   <= 1'b0;
        end else begin
            case (state_reg)
                STABLE: begin
                    if (sync2_reg != out_reg) begin
                        state_reg <= COUNTING;
                        count_reg <= CNT_W'(1);
                    end else begin
                        count_reg <= '0;
                    end
                end
                COUNTING: begin
                    if (sync2_reg == out_reg) begin
                        state_reg <= STABLE;
                        count_reg <= '0;
                    end else if (count_reg == N_CNT) begin
                        out_reg   <= sync2_reg;
                        count_reg <= '0;
                        state_reg <= STABLE;
                    end else begin
                        count_reg <= count_reg + CNT_W'(1);
                    end
                end
                default: begin
                    state_reg <= STABLE;
                    count_reg <= '0;
                end
            endcase
        end
    end

    assign button_out = out_reg;

`ifdef BUTTON_DEBOUNCER_EDGE_EN
    logic prev_out_reg;
    logic rise_reg;
    logic fall_reg;

    // Pulses appear the cycle after button_out moves; reset clears the history so no spurious edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prev_out_reg <= 1'b0;
            rise_reg     <= 1'b0;
            fall_reg     <= 1'b0;
        end else begin
            prev_out_reg <= out_reg;
            rise_reg     <= out_reg & ~prev_out_reg;
            fall_reg     <= ~out_reg & prev_out_reg;
        end
    end

    assign rise_pulse = rise_reg;
    assign fall_pulse = fall_reg;
`else
    assign rise_pulse = 1'b0;
    assign fall_pulse = 1'b0;
`endif

endmodule

// File: rtl/button_debouncer.sv
// Multi-channel button debouncer: one independent debounce_cell per input bit.
// Define BUTTON_DEBOUNCER_EDGE_EN to enable rise_pulse/fall_pulse generation.
module button_debouncer
    import button_debouncer_pkg::*;
#(
    parameter int CLOCK_FREQUENCY = 50000000,
    parameter int DEBOUNCE_MS     = 10,
    parameter int WIDTH           = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] button_in,
    output logic [WIDTH-1:0] button_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse
);

    localparam int N     = calc_n(CLOCK_FREQUENCY, DEBOUNCE_MS);
    localparam int CNT_W = calc_cnt_width(N);

    generate
        if (N < 2) begin : g_bad_params
            $error("button_debouncer: debounce count N=%0d must be at least 2", N);
        end
    endgenerate

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
            debounce_cell #(
                .N     (N),
                .CNT_W (CNT_W)
            ) u_cell (
                .clock      (clock),
                .reset_n    (reset_n),
                .button_in  (button_in[gi]),
                .button_out (button_out[gi]),
                .rise_pulse (rise_pulse[gi]),
                .fall_pulse (fall_pulse[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_button_debouncer.sv
// Scoreboard bench for button_debouncer (N=1000): reference model pushes expectations, monitor compares.
// Pulse expectations follow BUTTON_DEBOUNCER_EDGE_EN.
module tb_button_debouncer;

    localparam int CF = 1000000;
    localparam int MS = 1;
    localparam int W  = 4;
    localparam int N  = (CF / 1000) * MS;
`ifdef BUTTON_DEBOUNCER_EDGE_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    logic         clock;
    logic         reset_n;
    logic [W-1:0] button_in;
    logic [W-1:0] button_out;
    logic [W-1:0] rise_pulse;
    logic [W-1:0] fall_pulse;

    button_debouncer #(
        .CLOCK_FREQUENCY (CF),
        .DEBOUNCE_MS     (MS),
        .WIDTH           (W)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .button_in  (button_in),
        .button_out (button_out),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [W-1:0] out;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
    endtask

    // Reference model: an input is accepted once its synchronized level has differed
    // from the current debounced level for N+1 consecutive cycles.
    logic [W-1:0] m_pipe[2];
    logic [W-1:0] m_out;
    logic [W-1:0] m_prev;
    int           m_diff_len[W];

    initial begin
        forever begin
            @(posedge clock);
            if (!reset_n) begin
                m_pipe[0] = '0;
                m_pipe[1] = '0;
                m_out     = '0;
                m_prev    = '0;
                for (int c = 0; c < W; c++) m_diff_len[c] = 0;
                exp_q.push_back('0);
            end else begin
                exp_t e;
                logic [W-1:0] seen;
                e.rise = EDGE_EN ? (m_out & ~m_prev) : '0;
                e.fall = EDGE_EN ? (~m_out & m_prev) : '0;
                m_prev = m_out;
                seen   = m_pipe[1];
                for (int c = 0; c < W; c++) begin
                    if (seen[c] != m_out[c]) m_diff_len[c] = m_diff_len[c] + 1;
                    else m_diff_len[c] = 0;
                    if (m_diff_len[c] == N + 1) begin
                        m_out[c]      = seen[c];
                        m_diff_len[c] = 0;
                    end
                end
                m_pipe[1] = m_pipe[0];
                m_pipe[0] = button_in;
                e.out     = m_out;
                exp_q.push_back(e);
            end
        end
    end

    // Monitor: one expectation per clock, compared mid-cycle; an asserted reset forces zeros.
    initial begin
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                if (!reset_n) e = '0;
                check("scoreboard", 32'({button_out, rise_pulse, fall_pulse}),
                      32'({e.out, e.rise, e.fall}));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic wait_bit(input int ch, input logic val, output int cycles);
        cycles = 0;
        while (button_out[ch] !== val && cycles < 3000) begin
            tick(1);
            cycles++;
        end
    endtask

    task automatic wait_vec(input logic [W-1:0] val, output int cycles, output int first_move);
        logic [W-1:0] start;
        start      = button_out;
        cycles     = 0;
        first_move = -1;
        while (button_out !== val && cycles < 3000) begin
            tick(1);
            cycles++;
            if (first_move < 0 && button_out !== start) first_move = cycles;
        end
        if (first_move < 0) first_move = cycles;
    endtask

    task automatic pulse_test(input int len, input logic expect_hi, input string name);
        logic seen;
        seen = 1'b0;
        button_in[2] = 1'b1;
        for (int t = 0; t < len; t++) begin
            tick(1);
            if (button_out[2] || rise_pulse[2]) seen = 1'b1;
        end
        button_in[2] = 1'b0;
        for (int t = 0; t < 1100; t++) begin
            tick(1);
            if (button_out[2] || rise_pulse[2]) seen = 1'b1;
        end
        check(name, 32'(seen), 32'(expect_hi));
        tick(20);
    endtask

    function automatic int pick_hold();
        int r;
        r = int'($urandom_range(0, 9));
        if (r < 4) return int'($urandom_range(1, 50));
        if (r < 7) return int'($urandom_range(995, 1005));
        return int'($urandom_range(100, 1500));
    endfunction

    initial begin
        int   cyc;
        int   first;
        logic seen;
        logic [W-1:0] v;
        int   hold[W];

        reset_n   = 1'b0;
        button_in = '0;
        tick(3);
        reset_n = 1'b1;
        tick(5);

        // Single channel rise: latency and pulse placement
        button_in[0] = 1'b1;
        wait_bit(0, 1'b1, cyc);
        check("ch0_rise_latency", 32'(cyc), 32'(N + 3));
        check("ch0_rise_pulse_early", 32'(rise_pulse[0]), 32'd0);
        tick(1);
        check("ch0_rise_pulse", 32'(rise_pulse[0]), 32'(EDGE_EN));
        tick(1);
        check("ch0_rise_pulse_end", 32'(rise_pulse[0]), 32'd0);
        button_in[0] = 1'b0;
        wait_bit(0, 1'b0, cyc);
        check("ch0_fall_latency", 32'(cyc), 32'(N + 3));
        tick(1);
        check("ch0_fall_pulse", 32'(fall_pulse[0]), 32'(EDGE_EN));
        tick(10);

        // Periodic bounce shorter than N never passes, then a clean hold does
        seen = 1'b0;
        v    = '0;
        for (int t = 0; t < 5000; t++) begin
            if (t > 0 && t % 300 == 0) v[1] = ~v[1];
            button_in[1] = v[1];
            tick(1);
            if (button_out[1] || rise_pulse[1]) seen = 1'b1;
        end
        check("ch1_toggle_no_change", 32'(seen), 32'd0);
        button_in[1] = 1'b1;
        wait_bit(1, 1'b1, cyc);
        check("ch1_final_latency", 32'(cyc), 32'(N + 3));
        button_in[1] = 1'b0;
        tick(1100);

        // Boundary around the acceptance length
        pulse_test(N - 1, 1'b0, "ch2_short_999");
        pulse_test(N + 1, 1'b1, "ch2_long_1001");

        // All channels together
        button_in = '1;
        wait_vec('1, cyc, first);
        check("all_rise_latency", 32'(cyc), 32'(N + 3));
        check("all_rise_same_cycle", 32'(first), 32'(cyc));
        tick(1);
        check("all_rise_pulse", 32'(rise_pulse), EDGE_EN ? 32'hF : 32'h0);
        tick(2);
        button_in = '0;
        wait_vec('0, cyc, first);
        check("all_fall_latency", 32'(cyc), 32'(N + 3));
        check("all_fall_same_cycle", 32'(first), 32'(cyc));
        tick(1);
        check("all_fall_pulse", 32'(fall_pulse), EDGE_EN ? 32'hF : 32'h0);
        tick(10);

        // Reset mid-count, then restart from a held-high input
        button_in = '1;
        tick(502);
        reset_n = 1'b0;
        #1;
        check("reset_async_clear", 32'({button_out, rise_pulse, fall_pulse}), 32'd0);
        tick(3);
        check("reset_held_clear", 32'({button_out, rise_pulse, fall_pulse}), 32'd0);
        reset_n = 1'b1;
        wait_vec('1, cyc, first);
        check("post_reset_latency", 32'(cyc), 32'(N + 3));
        button_in = '0;
        tick(1100);

        // Randomized independent bouncing on all channels
        v = '0;
        for (int c = 0; c < W; c++) hold[c] = pick_hold();
        for (int t = 0; t < 12000; t++) begin
            for (int c = 0; c < W; c++) begin
                if (hold[c] == 0) begin
                    v[c]    = ~v[c];
                    hold[c] = pick_hold();
                end else begin
                    hold[c] = hold[c] - 1;
                end
            end
            button_in = v;
            tick(1);
        end
        button_in = '0;
        tick(1100);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
